enemy_row_phase_sequencer: RTL

Sequential owner of one enemy row. It stores each enemy's alive flag and 19-bit packed position, and generates the 2-bit movement phase. On each movement step it advances every live enemy horizontally according to the phase. It consumes the frame tick and player hit events, and feeds the row renderer and collision logic.

---
 rtl/enemy_row_phase_sequencer_pkg.sv | 28 ++
 rtl/enemy_row_phase_sequencer_slot.sv | 40 ++++
 rtl/enemy_row_phase_sequencer.sv | 106 ++++++++++
 3 files changed

// File: rtl/enemy_row_phase_sequencer_pkg.sv
// Shared encodings for the enemy row sequencer: position fields, the dead-slot code,
// movement phases and sequencer states.
package enemy_row_phase_sequencer_pkg;

  localparam int unsigned X_W   = 10;
  localparam int unsigned Y_W   = 9;
  localparam int unsigned POS_W = X_W + Y_W;

  localparam logic [POS_W-1:0] NONE = 19'h7FFFF;

  typedef enum logic [1:0] {
    PH_LEFT0  = 2'b00,
    PH_RIGHT0 = 2'b01,
    PH_RIGHT1 = 2'b10,
    PH_LEFT1  = 2'b11
  } phase_t;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StRun     = 2'b01,
    StCleared = 2'b10
  } seqState_t;

  function automatic logic movesRight(input phase_t ph);
    return (ph == PH_RIGHT0) || (ph == PH_RIGHT1);
  endfunction

endpackage

// File: rtl/enemy_row_phase_sequencer_slot.sv
// One enemy: alive flag plus packed {x, y} position. Load beats hit, hit beats step,
// so a destroyed enemy never moves on the cycle it dies.
module enemy_slot
  import enemy_row_phase_sequencer_pkg::*;
#(
  parameter logic [Y_W-1:0] VERTICAL_POSITION = 9'd48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             hit,
  input  logic [1:0]       phase,
  input  logic [X_W-1:0]   loadX,
  output logic             alive,
  output logic [POS_W-1:0] position
);

  logic [X_W-1:0] x;
  logic [X_W-1:0] xNext;

  assign x     = position[POS_W-1:Y_W];
  assign xNext = movesRight(phase_t'(phase)) ? x + X_W'(1) : x - X_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive    <= 1'b0;
      position <= NONE;
    end else if (load) begin
      alive    <= 1'b1;
      position <= {loadX, VERTICAL_POSITION};
    end else if (hit && alive) begin
      alive    <= 1'b0;
      position <= NONE;
    end else if (step && alive) begin
      position <= {xNext, VERTICAL_POSITION};
    end
  end

endmodule

// File: rtl/enemy_row_phase_sequencer.sv
// Owns one enemy row: run/cleared FSM, frame and step counters, movement phase,
// and one enemy_slot per enemy.
module enemy_row_phase_sequencer
  import enemy_row_phase_sequencer_pkg::*;
#(
  parameter int unsigned    N_ENEMY           = 8,
  parameter logic [Y_W-1:0] VERTICAL_POSITION = 9'd48,
  parameter logic [X_W-1:0] START_X           = 10'd64,
  parameter logic [X_W-1:0] SPACING_X         = 10'd48,
  parameter int unsigned    FRAMES_PER_STEP   = 4,
  parameter int unsigned    STEPS_PER_PHASE   = 16
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst_n,
  input  logic                     i_Start,
  input  logic                     i_FrameTick,
  input  logic                     i_HitValid,
  input  logic [2:0]               i_HitIndex,
  output logic [1:0]               o_PhaseState,
  output logic [N_ENEMY-1:0]       o_EnemyState,
  output logic [POS_W*N_ENEMY-1:0] o_EnemyPosition,
  output logic                     o_StepPulse,
  output logic                     o_RowCleared
);

  localparam int unsigned FC_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int unsigned SC_W = (STEPS_PER_PHASE > 1) ? $clog2(STEPS_PER_PHASE) : 1;
  localparam logic [FC_W-1:0] FRAME_LAST = FC_W'(FRAMES_PER_STEP - 1);
  localparam logic [SC_W-1:0] STEP_LAST  = SC_W'(STEPS_PER_PHASE - 1);

  seqState_t       state;
  phase_t          phase;
  logic [FC_W-1:0] frameCnt;
  logic [SC_W-1:0] stepCnt;
  logic            running;
  logic            stepNow;
  logic            hitEn;

  // A pending restart suppresses every same-cycle tick and hit.
  assign running = (state == StRun) && !i_Start && (|o_EnemyState);
  assign stepNow = running && i_FrameTick && (frameCnt == FRAME_LAST);
  assign hitEn   = running && i_HitValid;

  assign o_PhaseState = phase;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state        <= StIdle;
      phase        <= PH_LEFT0;
      frameCnt     <= '0;
      stepCnt      <= '0;
      o_StepPulse  <= 1'b0;
      o_RowCleared <= 1'b0;
    end else begin
      o_StepPulse <= stepNow;
      if (i_Start) begin
        state        <= StRun;
        phase        <= PH_LEFT0;
        frameCnt     <= '0;
        stepCnt      <= '0;
        o_RowCleared <= 1'b0;
      end else begin
        case (state)
          StRun: begin
            if (o_EnemyState == '0) begin
              state        <= StCleared;
              o_RowCleared <= 1'b1;
            end else if (i_FrameTick) begin
              if (frameCnt == FRAME_LAST) begin
                frameCnt <= '0;
                if (stepCnt == STEP_LAST) begin
                  stepCnt <= '0;
                  phase   <= phase_t'(phase + 2'd1);
                end else begin
                  stepCnt <= stepCnt + 1'b1;
                end
              end else begin
                frameCnt <= frameCnt + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  for (genvar k = 0; k < N_ENEMY; k++) begin : gSlot
    localparam logic [X_W-1:0] LOAD_X = X_W'(START_X + k * SPACING_X);

    enemy_slot #(
      .VERTICAL_POSITION(VERTICAL_POSITION)
    ) u_slot (
      .clk     (i_Clk),
      .rst_n   (i_Rst_n),
      .load    (i_Start),
      .step    (stepNow),
      .hit     (hitEn && (i_HitIndex == 3'(k))),
      .phase   (phase),
      .loadX   (LOAD_X),
      .alive   (o_EnemyState[k]),
      .position(o_EnemyPosition[POS_W*k +: POS_W])
    );
  end

endmodule
